// File: rtl/pipe_flow_ctrl.sv
// Sequential half of the ID-stage hazard unit: PC, IF/ID register, detector
// feedback history, ID/EX valid bit and saturating stall/flush event counters.
module pipe_flow_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      imem_ins,
    input  logic [1:0]       tag,
    input  logic             flush,
    input  logic             bubble,
    input  logic             pc_en,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_ins,
    output logic [31:0]      if_id_pc4,
    output logic [1:0]       flag,
    output logic [4:0]       rd_q,
    output logic             id_ex_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] TAG_LW  = 2'd1;
    localparam logic [1:0] TAG_BEQ = 2'd2;
    localparam logic [1:0] TAG_J   = 2'd3;

    logic [31:0]      r_pc;
    logic [31:0]      r_if_id_ins;
    logic [31:0]      r_if_id_pc4;
    logic [1:0]       r_flag;
    logic [4:0]       r_rd_q;
    logic             r_id_ex_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_pc_next;
    logic        w_stall;
    logic        w_kill;

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_tgt = r_if_id_pc4 + {{14{r_if_id_ins[15]}}, r_if_id_ins[15:0], 2'b00};
    assign w_j_tgt  = {r_if_id_pc4[31:28], r_if_id_ins[25:0], 2'b00};
    assign w_stall  = ~pc_en;
    assign w_kill   = pc_en & ~flush;

    always_comb begin
        w_pc_next = w_pc4;
        if (tag == TAG_J)
            w_pc_next = w_j_tgt;
        else if (tag == TAG_BEQ)
            w_pc_next = w_br_tgt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_ins   <= NOP_INS;
            r_if_id_pc4   <= 32'd0;
            r_flag        <= 2'd0;
            r_rd_q        <= 5'd0;
            r_id_ex_valid <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_id_ex_valid <= bubble;
            if (w_stall) begin
                // The lw has already moved on, so clearing flag keeps the
                // load-use stall from firing a second time on the same pair.
                r_flag <= 2'd0;
                if (r_stall_cnt != {CNT_W{1'b1}})
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_pc   <= w_pc_next;
                r_flag <= tag;
                if (tag == TAG_LW)
                    r_rd_q <= r_if_id_ins[20:16];
                if (w_kill) begin
                    r_if_id_ins <= NOP_INS;
                    if (r_flush_cnt != {CNT_W{1'b1}})
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                end else begin
                    r_if_id_ins <= imem_ins;
                    r_if_id_pc4 <= w_pc4;
                end
            end
        end
    end

    assign pc          = r_pc;
    assign if_id_ins   = r_if_id_ins;
    assign if_id_pc4   = r_if_id_pc4;
    assign flag        = r_flag;
    assign rd_q        = r_rd_q;
    assign id_ex_valid = r_id_ex_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed plus randomized bench for pipe_flow_ctrl, checked against a
// behavioural pipeline model that applies the PC/IF-ID/history rules per cycle.
module tb_pipe_flow_ctrl;

    localparam int          CNT_W   = 6;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      imem_ins;
    logic [1:0]       tag;
    logic             flush;
    logic             bubble;
    logic             pc_en;
    logic [31:0]      pc;
    logic [31:0]      if_id_ins;
    logic [31:0]      if_id_pc4;
    logic [1:0]       flag;
    logic [4:0]       rd_q;
    logic             id_ex_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [31:0] m_pc, m_ins, m_pc4;
    logic [1:0]  m_flag;
    logic [4:0]  m_rd;
    logic        m_valid;
    int          m_stall, m_flush;

    pipe_flow_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_ins    (imem_ins),
        .tag         (tag),
        .flush       (flush),
        .bubble      (bubble),
        .pc_en       (pc_en),
        .pc          (pc),
        .if_id_ins   (if_id_ins),
        .if_id_pc4   (if_id_pc4),
        .flag        (flag),
        .rd_q        (rd_q),
        .id_ex_valid (id_ex_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = NOP; m_pc4 = 32'h0;
        m_flag = 2'd0; m_rd = 5'd0; m_valid = 1'b0;
        m_stall = 0; m_flush = 0;
    endtask

    // One rising edge of the pipeline, evaluated from the architectural rules.
    task automatic model_clock();
        int          imm;
        logic [31:0] next_pc;
        m_valid = bubble;
        if (!pc_en) begin
            m_flag = 2'd0;
            if (m_stall < CNT_MAX) m_stall = m_stall + 1;
        end else begin
            imm = int'($signed(m_ins[15:0]));
            if (tag == 2'd3)      next_pc = {m_pc4[31:28], m_ins[25:0], 2'b00};
            else if (tag == 2'd2) next_pc = m_pc4 + 32'(imm * 4);
            else                  next_pc = m_pc + 32'd4;
            if (tag == 2'd1) m_rd = m_ins[20:16];
            m_flag = tag;
            if (!flush) begin
                m_ins = NOP;
                if (m_flush < CNT_MAX) m_flush = m_flush + 1;
            end else begin
                m_ins = imem_ins;
                m_pc4 = m_pc + 32'd4;
            end
            m_pc = next_pc;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".pc"},        pc,                  m_pc);
        check({ph, ".ins"},       if_id_ins,           m_ins);
        check({ph, ".pc4"},       if_id_pc4,           m_pc4);
        check({ph, ".flag"},      32'(flag),           32'(m_flag));
        check({ph, ".rd_q"},      32'(rd_q),           32'(m_rd));
        check({ph, ".valid"},     32'(id_ex_valid),    32'(m_valid));
        check({ph, ".stall_cnt"}, 32'(stall_cnt),      32'(m_stall));
        check({ph, ".flush_cnt"}, 32'(flush_cnt),      32'(m_flush));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [1:0] t,
                         input logic fl, input logic bu, input logic pe);
        imem_ins = ins; tag = t; flush = fl; bubble = bu; pc_en = pe;
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_clock();
        #1;
        check_all(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 2'd0, 1'b1, 1'b1, 1'b1);
        model_reset();
        #3;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Free run: pc 0,4,8,C and IF/ID trails fetch by one cycle.
        for (int i = 0; i < 4; i++) begin
            drive($urandom, 2'd0, 1'b1, 1'b1, 1'b1);
            step("free");
        end
        check("free.pc_seq", pc, 32'h0000_0010);

        // Jump: 0800_0010 fetched at pc=4 -> target 0x40.
        do_reset();
        drive(32'h1234_5678, 2'd0, 1'b1, 1'b1, 1'b1); step("j.f0");
        drive(32'h0800_0010, 2'd0, 1'b1, 1'b1, 1'b1); step("j.f1");
        check("j.pc4_setup", if_id_pc4, 32'h0000_0008);
        drive($urandom, 2'd3, 1'b0, 1'b1, 1'b1); step("j.redir");
        check("j.tgt", pc, 32'h0000_0040);
        check("j.nop", if_id_ins, NOP);
        drive($urandom, 2'd0, 1'b1, 1'b0, 1'b1); step("j.bubble");
        check("j.valid0", 32'(id_ex_valid), 32'd0);

        // Taken beq with imm=-2 from pc4=0x20 -> 0x18.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive($urandom, 2'd0, 1'b1, 1'b1, 1'b1); step("b.run");
        end
        drive(32'h1000_FFFE, 2'd0, 1'b1, 1'b1, 1'b1); step("b.fetch");
        drive($urandom, 2'd2, 1'b0, 1'b1, 1'b1); step("b.redir");
        check("b.tgt", pc, 32'h0000_0018);
        check("b.fcnt", 32'(flush_cnt), 32'd1);

        // Load-use: lw rt=5, one stall cycle, then fetch resumes.
        drive(32'h8C05_0000, 2'd0, 1'b1, 1'b1, 1'b1); step("lu.fetch");
        drive($urandom, 2'd1, 1'b1, 1'b1, 1'b1); step("lu.id");
        check("lu.rd", 32'(rd_q), 32'd5);
        check("lu.flag1", 32'(flag), 32'd1);
        drive($urandom, 2'd0, 1'b0, 1'b0, 1'b0); step("lu.stall");
        check("lu.flag0", 32'(flag), 32'd0);
        check("lu.scnt", 32'(stall_cnt), 32'd1);
        drive($urandom, 2'd0, 1'b1, 1'b1, 1'b1); step("lu.resume");

        // PC wrap: branch from pc4=4 with imm=-2 lands on FFFF_FFFC.
        do_reset();
        drive(32'h1000_FFFE, 2'd0, 1'b1, 1'b1, 1'b1); step("w.fetch");
        drive($urandom, 2'd2, 1'b0, 1'b1, 1'b1); step("w.redir");
        check("w.top", pc, 32'hFFFF_FFFC);
        drive($urandom, 2'd0, 1'b1, 1'b1, 1'b1); step("w.wrap");
        check("w.zero", pc, 32'h0000_0000);

        // Randomized traffic, including tag/flush/pc_en combinations.
        for (int i = 0; i < 400; i++) begin
            drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
            step("rand");
        end

        // Counter saturation.
        do_reset();
        for (int i = 0; i < CNT_MAX + 8; i++) begin
            drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            step("sat.stall");
        end
        check("sat.scnt", 32'(stall_cnt), 32'(CNT_MAX));
        for (int i = 0; i < CNT_MAX + 8; i++) begin
            drive($urandom, 2'd0, 1'b0, 1'b1, 1'b1);
            step("sat.flush");
        end
        check("sat.fcnt", 32'(flush_cnt), 32'(CNT_MAX));

        // Asynchronous reset in the middle of a stall.
        drive($urandom, 2'd3, 1'b0, 1'b0, 1'b0);
        step("ar.stall");
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("ar.async");
        @(negedge clk);
        rst = 1'b0;
        drive(32'hDEAD_BEEF, 2'd0, 1'b1, 1'b1, 1'b1);
        step("ar.first");
        check("ar.first_fetch", if_id_pc4, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Sequential partner of the ID-stage hazard detector. It owns the PC register, the IF/ID pipeline register, the flag/rd history fed back to the detector, and the ID/EX valid bit. It consumes the detector's active-low flush, bubble and pc_en strobes and its tag, and it computes the next PC (sequential, taken branch, jump). It also keeps saturating stall and flush event counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INS, 32'h0000_0000, instruction word injected into IF/ID on a kill.
CNT_W, 16, width of the stall and flush event counters.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
imem_ins  in  32  instruction read from instruction memory at address pc
tag  in  2  detector tag for if_id_ins: 0 none, 1 lw, 2 taken beq, 3 j
flush  in  1  active-low: kill (or hold, if pc_en=0) IF/ID
bubble  in  1  active-low: insert bubble into ID/EX
pc_en  in  1  active-low stall: 0 freezes pc and IF/ID
pc  out  32  current fetch address
if_id_ins  out  32  instruction held in ID
if_id_pc4  out  32  pc+4 of the instruction held in ID
flag  out  2  registered tag of the previous ID instruction, to detector
rd_q  out  5  destination (rt, bits 20:16) of the last lw seen in ID, to detector
id_ex_valid  out  1  1 = ID/EX carries a real instruction, 0 = bubble
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  cycles with flush=0 and pc_en=1, saturating

Behaviour:
- Reset (async, immediate): pc=RESET_PC, if_id_ins=NOP_INS, if_id_pc4=0, flag=0, rd_q=0, id_ex_valid=0, stall_cnt=0, flush_cnt=0.
- Targets are computed from if_id_ins and if_id_pc4:
  - br_tgt = if_id_pc4 + (sign-extend ins[15:0] << 2)
  - j_tgt = {if_id_pc4[31:28], ins[25:0], 2'b00}
  - All adds are 32-bit mod 2^32. pc+4 wraps 32'hFFFF_FFFC to 0.
- PC update, priority order:
  - pc_en=0: hold.
  - else tag=3: pc <= j_tgt.
  - else tag=2: pc <= br_tgt.
  - else pc <= pc+4.
- IF/ID update:
  - pc_en=0: hold both if_id_ins and if_id_pc4, regardless of flush.
  - pc_en=1, flush=0: if_id_ins <= NOP_INS; if_id_pc4 holds (kill wrong-path fetch).
  - pc_en=1, flush=1: if_id_ins <= imem_ins; if_id_pc4 <= pc+4.
- History registers:
  - pc_en=1: flag <= tag. If tag=1, rd_q <= if_id_ins[20:16]; otherwise rd_q holds.
  - pc_en=0: flag <= 0 and rd_q holds. The lw has advanced, so the one-cycle load-use stall cannot re-trigger on itself.
- id_ex_valid <= bubble every cycle; a 0 kills the instruction entering EX.
- Latency:
  - Redirect: tag=2/3 in cycle N gives pc = target in N+1.
  - Load-use: exactly one stall cycle per lw→dependent pair.
- Counters:
  - stall_cnt +1 on each cycle with pc_en=0.
  - flush_cnt +1 on each cycle with flush=0 and pc_en=1.
  - Both hold at all-ones and never wrap.
- Simultaneous events: pc_en=0 overrides any tag redirect and any flush-kill; only flag, id_ex_valid and the counters update.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values asynchronously. The first fetch after release is RESET_PC.

Test Plan:
- Reset then free-run with flush=bubble=pc_en=1, tag=0 → pc sequence 0,4,8,C; if_id_ins follows imem_ins one cycle later; id_ex_valid=1 from cycle 2.
- Jump: if_id_ins=32'h0800_0010, if_id_pc4=32'h0000_0008, tag=3, flush=0 → next pc=32'h0000_0040, if_id_ins=NOP, flag=3; with bubble=0 the following cycle → id_ex_valid=0.
- Taken beq: if_id_ins imm=16'hFFFE, if_id_pc4=32'h0000_0020, tag=2, flush=0 → next pc=32'h0000_0018, flush_cnt+1.
- Load-use: lw with rt=5 in ID (tag=1) → rd_q=5, flag=1; next cycle pc_en=0, flush=0, bubble=0 → pc and IF/ID hold, flag=0, id_ex_valid=0, stall_cnt=1; fetch resumes the cycle after.
- Saturation: force pc_en=0 for 70000 cycles with CNT_W=16 → stall_cnt=16'hFFFF and it stays there.
- Wrap and reset: pc=32'hFFFF_FFFC with tag=0 → pc=0; assert rst during a pc_en=0 stall → all outputs return to reset values immediately, without waiting for a clock edge.
